// File: rtl/niski_io_pkg.sv
// Shared types and default timing constants for the board push-button input path.
package niski_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } repeat_state_t;

    localparam int BTN_DEBOUNCE_CYCLES = 4;
    localparam int BTN_REPEAT_DELAY    = 20;
    localparam int BTN_REPEAT_PERIOD   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-FF synchroniser, debounce counter and hold-to-repeat FSM.
module button_channel
    import niski_io_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    input  logic repeat_en_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic repeat_pulse_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY);
    localparam logic [RP_W-1:0] RP_PERIOD = RP_W'(REPEAT_PERIOD);
    localparam logic [RP_W-1:0] RP_ONE    = RP_W'(1);

    logic            s1_q, s2_q;
    logic            act;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pressed_q, pressed_d;
    logic            press_evt, release_evt;
    logic            press_pulse_q, release_pulse_q;
    logic            repeat_pulse_q, repeat_pulse_d;
    repeat_state_t   state_q, state_d;
    logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;

    // Synchroniser idles at the inactive pin level so reset never looks like a press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= ACTIVE_LOW;
            s2_q <= ACTIVE_LOW;
        end else begin
            s1_q <= pin_i;
            s2_q <= s1_q;
        end
    end

    assign act = s2_q ^ ACTIVE_LOW;

    always_comb begin
        db_cnt_d    = db_cnt_q;
        pressed_d   = pressed_q;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        if (act == pressed_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d    = '0;
            pressed_d   = ~pressed_q;
            press_evt   = ~pressed_q;
            release_evt = pressed_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
        end
    end

    // A release, or dropping the enable, always beats a repeat that falls due.
    always_comb begin
        state_d        = state_q;
        rp_cnt_d       = rp_cnt_q;
        repeat_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (repeat_en_i && (press_evt || (pressed_q && !release_evt))) begin
                    state_d  = DELAY;
                    rp_cnt_d = RP_ONE;
                end
            end
            DELAY, REPEAT: begin
                if (release_evt || !repeat_en_i) begin
                    state_d  = IDLE;
                    rp_cnt_d = '0;
                end else if (rp_cnt_q == ((state_q == DELAY) ? RP_DELAY : RP_PERIOD)) begin
                    state_d        = REPEAT;
                    rp_cnt_d       = RP_ONE;
                    repeat_pulse_d = 1'b1;
                end else begin
                    rp_cnt_d = rp_cnt_q + RP_ONE;
                end
            end
            default: begin
                state_d  = IDLE;
                rp_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_cnt_q        <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            repeat_pulse_q  <= 1'b0;
            state_q         <= IDLE;
            rp_cnt_q        <= '0;
        end else begin
            db_cnt_q        <= db_cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_evt;
            release_pulse_q <= release_evt;
            repeat_pulse_q  <= repeat_pulse_d;
            state_q         <= state_d;
            rp_cnt_q        <= rp_cnt_d;
        end
    end

    assign pressed_o       = pressed_q;
    assign press_pulse_o   = press_pulse_q;
    assign release_pulse_o = release_pulse_q;
    assign repeat_pulse_o  = repeat_pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button conditioner: one independent button_channel per pin.
module button_conditioner
    import niski_io_pkg::*;
#(
    parameter int CHANNELS        = 5,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_pins,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        button_channel #(
            .ACTIVE_LOW     (ACTIVE_LOW),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .pin_i          (btn_pins[i]),
            .repeat_en_i    (repeat_en[i]),
            .pressed_o      (pressed[i]),
            .press_pulse_o  (press_pulse[i]),
            .release_pulse_o(release_pulse[i]),
            .repeat_pulse_o (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: 5 active-low channels, debounce 4, repeat 20/8.
module tb_button_conditioner;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_pins;
    logic [N-1:0] repeat_en;
    logic [N-1:0] pressed;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] repeat_pulse;

    int checks = 0;
    int errors = 0;
    int edgeNo = 0;
    int pressCnt[N];
    int releaseCnt[N];
    int repeatCnt[N];
    int pressEdge[N];
    int releaseEdge[N];
    int firstRepeatEdge[N];
    int rp1Edges[$];
    logic [N-1:0] seenAny;
    logic [N-1:0] overlap;

    always #5 clk = ~clk;

    button_conditioner #(
        .CHANNELS       (N),
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_pins     (btn_pins),
        .repeat_en    (repeat_en),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < N; i++) begin
            pressCnt[i]        = 0;
            releaseCnt[i]      = 0;
            repeatCnt[i]       = 0;
            pressEdge[i]       = -1;
            releaseEdge[i]     = -1;
            firstRepeatEdge[i] = -1;
        end
        rp1Edges.delete();
        seenAny = '0;
        overlap = '0;
    endtask

    // Advance one clock and log every strobe with the edge number it appeared on.
    task automatic stepEdge();
        @(posedge clk);
        #1;
        edgeNo++;
        for (int i = 0; i < N; i++) begin
            if (press_pulse[i]) begin
                pressCnt[i]++;
                pressEdge[i] = edgeNo;
            end
            if (release_pulse[i]) begin
                releaseCnt[i]++;
                releaseEdge[i] = edgeNo;
            end
            if (repeat_pulse[i]) begin
                if (repeatCnt[i] == 0) firstRepeatEdge[i] = edgeNo;
                repeatCnt[i]++;
                if (i == 1) rp1Edges.push_back(edgeNo);
            end
        end
        seenAny |= pressed | press_pulse | release_pulse | repeat_pulse;
        overlap |= press_pulse & repeat_pulse;
    endtask

    task automatic applyStimulus(input logic [N-1:0] pins, input logic [N-1:0] en, input int edges);
        btn_pins  = pins;
        repeat_en = en;
        repeat (edges) stepEdge();
    endtask

    initial begin
        int e0;
        int riseEdge;
        logic [N-1:0] pins;

        rst_n     = 1'b0;
        btn_pins  = 5'b11111;
        repeat_en = 5'b00000;
        clearCounts();

        // Reset, then a quiet idle period.
        applyStimulus(5'b11111, 5'b00000, 3);
        checkOutput("reset_outputs", {pressed, press_pulse, release_pulse, repeat_pulse}, 0);
        rst_n = 1'b1;
        clearCounts();
        applyStimulus(5'b11111, 5'b00000, 50);
        checkOutput("reset_quiet_50", seenAny, 0);

        // Clean press and release on channel 3.
        clearCounts();
        e0 = edgeNo + 1;
        applyStimulus(5'b10111, 5'b00000, 5);
        checkOutput("clean_no_early_press", pressed, 0);
        applyStimulus(5'b10111, 5'b00000, 1);
        checkOutput("clean_pressed", pressed, 5'b01000);
        checkOutput("clean_press_pulse", press_pulse, 5'b01000);
        applyStimulus(5'b10111, 5'b00000, 1);
        checkOutput("clean_pulse_width", press_pulse, 0);
        checkOutput("clean_press_latency", pressEdge[3] - e0, 5);
        e0 = edgeNo + 1;
        applyStimulus(5'b11111, 5'b00000, 5);
        checkOutput("clean_still_pressed", pressed, 5'b01000);
        applyStimulus(5'b11111, 5'b00000, 1);
        checkOutput("clean_release_pulse", release_pulse, 5'b01000);
        checkOutput("clean_released", pressed, 0);
        applyStimulus(5'b11111, 5'b00000, 3);
        checkOutput("clean_release_latency", releaseEdge[3] - e0, 5);
        checkOutput("clean_release_count", releaseCnt[3], 1);

        // Bouncing pin on channel 2 settles low.
        clearCounts();
        pins = 5'b11111;
        for (int t = 0; t < 6; t++) begin
            pins[2] = ~pins[2];
            applyStimulus(pins, 5'b00000, 2);
        end
        checkOutput("bounce_no_press_yet", pressCnt[2], 0);
        pins[2] = 1'b0;
        e0 = edgeNo + 1;
        applyStimulus(pins, 5'b00000, 5);
        checkOutput("bounce_no_early_press", pressed, 0);
        applyStimulus(pins, 5'b00000, 1);
        checkOutput("bounce_press_pulse", press_pulse, 5'b00100);
        applyStimulus(pins, 5'b00000, 4);
        checkOutput("bounce_press_count", pressCnt[2], 1);
        checkOutput("bounce_release_count", releaseCnt[2], 0);
        applyStimulus(5'b11111, 5'b00000, 8);
        checkOutput("bounce_final_release", releaseCnt[2], 1);

        // Auto-repeat on channel 1, released between repeats.
        clearCounts();
        applyStimulus(5'b11111, 5'b00010, 2);
        e0 = edgeNo + 1;
        applyStimulus(5'b11101, 5'b00010, 58);
        applyStimulus(5'b11111, 5'b00010, 12);
        checkOutput("rep_press_latency", pressEdge[1] - e0, 5);
        checkOutput("rep_count", repeatCnt[1], 5);
        for (int k = 0; k < 5; k++) begin
            if (k < rp1Edges.size())
                checkOutput($sformatf("rep_offset_%0d", k), rp1Edges[k] - pressEdge[1], 20 + 8 * k);
        end
        checkOutput("rep_release_offset", releaseEdge[1] - pressEdge[1], 58);
        checkOutput("rep_press_repeat_overlap", overlap, 0);

        // Release lands on the cycle a repeat is due: the repeat is suppressed.
        clearCounts();
        applyStimulus(5'b11101, 5'b00010, 28);
        applyStimulus(5'b11111, 5'b00010, 12);
        checkOutput("due_repeat_count", repeatCnt[1], 1);
        checkOutput("due_first_repeat", firstRepeatEdge[1] - pressEdge[1], 20);
        checkOutput("due_release_offset", releaseEdge[1] - pressEdge[1], 28);

        // Simultaneous presses, disabled repeat, then a late enable on channel 0.
        clearCounts();
        applyStimulus(5'b01110, 5'b00000, 6);
        checkOutput("simul_press_pulse", press_pulse, 5'b10001);
        applyStimulus(5'b01110, 5'b00000, 40);
        checkOutput("disabled_no_repeat", repeatCnt[0] + repeatCnt[4], 0);
        riseEdge = edgeNo + 1;
        applyStimulus(5'b01110, 5'b00001, 24);
        checkOutput("late_enable_first_repeat", firstRepeatEdge[0] - riseEdge, 20);
        checkOutput("late_enable_other_chan", repeatCnt[4], 0);
        applyStimulus(5'b11111, 5'b00000, 5);
        applyStimulus(5'b11111, 5'b00000, 1);
        checkOutput("simul_release_pulse", release_pulse, 5'b10001);
        applyStimulus(5'b11111, 5'b00000, 4);

        // Asynchronous reset while channel 1 is repeating.
        clearCounts();
        applyStimulus(5'b11101, 5'b00010, 30);
        checkOutput("midhold_repeating", repeatCnt[1], 1);
        checkOutput("midhold_pressed", pressed, 5'b00010);
        rst_n = 1'b0;
        #1;
        checkOutput("midhold_reset_clears", {pressed, press_pulse, release_pulse, repeat_pulse}, 0);
        applyStimulus(5'b11101, 5'b00010, 3);
        rst_n = 1'b1;
        clearCounts();
        applyStimulus(5'b11101, 5'b00010, 5);
        checkOutput("midhold_no_early_press", pressed, 0);
        applyStimulus(5'b11101, 5'b00010, 1);
        checkOutput("midhold_repress_pulse", press_pulse, 5'b00010);
        checkOutput("midhold_repressed", pressed, 5'b00010);
        applyStimulus(5'b11111, 5'b00000, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
